sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
CPU-side initiator for the base asynchronous SRAM on the thinpad board. It drives base_ram_addr, base_ram_data, base_ram_be_n, base_ram_ce_n and base_ram_we_n toward the board SRAM. It turns a single-word request/acknowledge bus from the memory stage or MMU into correctly timed SRAM read and write cycles. It sits inside thinpad_top, between the bus arbiter and the base RAM pins.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 32, data width; byte enables = DATA_W/8
WAIT_CYCLES, 1, extra cycles the ACCESS state is held (ACCESS lasts WAIT_CYCLES+1 cycles); legal range 0..7

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
req_i  in  1  request; sampled only in IDLE
we_i  in  1  1 = write, 0 = read
addr_i  in  ADDR_W  word address
wdata_i  in  DATA_W  write data
be_i  in  DATA_W/8  byte enables, active-high
rdata_o  out  DATA_W  read data, registered
ack_o  out  1  one-cycle completion pulse
busy_o  out  1  high whenever state != IDLE
base_ram_data  inout  DATA_W  SRAM data bus
base_ram_addr  out  ADDR_W  SRAM address
base_ram_be_n  out  DATA_W/8  SRAM byte enables, active-low
base_ram_ce_n  out  1  SRAM chip enable, active-low
base_ram_we_n  out  1  SRAM write enable, active-low

Behaviour:
- Decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; ce_n=1; we_n=1; be_n=all 1; base_ram_addr=0; base_ram_data=Z; rdata_o=0; ack_o=0; busy_o=0.
- All pin outputs are registered. No combinational path from req_i to any pin.
- FSM states: IDLE, SETUP, ACCESS, HOLD, DONE. A wait counter counts WAIT_CYCLES..0 inside ACCESS.
- IDLE with req_i=1 accepts the request on that edge (edge T0).
  - addr_i, we_i, wdata_i and ~be_i are latched into the pin registers.
  - Inputs are ignored from then until the state returns to IDLE.
- Read path: IDLE -> ACCESS -> DONE.
  - ACCESS: ce_n=0, we_n=1, data bus Z.
  - On the edge leaving the last ACCESS cycle, base_ram_data is captured into rdata_o.
  - DONE: ce_n=1, ack_o=1.
  - ack_o is high in cycle T0+2+WAIT_CYCLES.
- Write path: IDLE -> SETUP -> ACCESS -> HOLD -> DONE.
  - SETUP: ce_n=0, we_n=1, data driven.
  - ACCESS: we_n=0, data driven.
  - HOLD: we_n=1, ce_n=0, data still driven.
  - DONE: ce_n=1, data Z, ack_o=1.
  - ack_o is high in cycle T0+4+WAIT_CYCLES.
  - Address and data are stable for the whole time we_n=0, plus one cycle on each side.
- DONE always goes to IDLE, so back-to-back requests have one IDLE cycle between them. If req_i is still high in that IDLE cycle, a new transaction starts; the requester must drop req_i after seeing ack_o.
- base_ram_data is driven only in SETUP, ACCESS and HOLD of a write. It is high-Z in every other state and during reset.
- rdata_o holds the last read value until the next read completes; writes never change it.
- A write with be_i=0 still runs the full cycle, with be_n=all 1s.
- Reset asserted mid-transaction:
  - On the next edge, every output takes its reset value and the data bus is released.
  - No ack_o is produced for the aborted transaction.
  - An aborted write may have partially written the SRAM; this is accepted.

Test Plan:
- Reset: hold rst 3 cycles with req_i=1 -> ce_n=1, we_n=1, be_n=1111, data=Z, ack_o=0, busy_o=0 throughout; after release, a request is accepted on the first IDLE edge.
- Read, WAIT_CYCLES=1: model holds 0xDEADBEEF at 0x00010; req read be=1111 -> ce_n low exactly 2 cycles with we_n=1; ack_o in cycle T0+3; rdata_o=0xDEADBEEF.
- Write, WAIT_CYCLES=1: addr 0x0ABCD, data 0x12345678, be=0011 -> be_n=1100; we_n low exactly 2 cycles; data stable from SETUP through HOLD; ack_o in cycle T0+5; readback returns 0x????5678 with upper bytes unchanged.
- Back-to-back: write then read of the same address, req_i held high -> exactly one IDLE cycle between the transactions; read returns the written value; changing addr_i while busy has no effect on base_ram_addr.
- Abort: assert rst during write ACCESS -> next edge we_n=1, ce_n=1, data=Z; no ack_o.
- WAIT_CYCLES=0 build: read ack_o at T0+2; write ack_o at T0+4; we_n low exactly 1 cycle.

Source files
------------

// File: rtl/sram_ctrl.sv
// Single-word request/ack initiator for the thinpad base asynchronous SRAM.
// Read: IDLE->ACCESS->DONE; write: IDLE->SETUP->ACCESS->HOLD->DONE. All pins registered.
module sram_ctrl #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   be_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  ack_o,
  output logic                  busy_o,
  inout  wire  [DATA_W-1:0]     base_ram_data,
  output logic [ADDR_W-1:0]     base_ram_addr,
  output logic [DATA_W/8-1:0]   base_ram_be_n,
  output logic                  base_ram_ce_n,
  output logic                  base_ram_we_n
);

  localparam int unsigned BeW      = DATA_W / 8;
  localparam logic [2:0]  WaitInit = 3'(WAIT_CYCLES);

  typedef enum logic [2:0] {StIdle, StSetup, StAccess, StHold, StDone} state_t;

  state_t              r_state, w_state_d;
  logic [2:0]          r_cnt, w_cnt_d;
  logic                r_dir, w_dir_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [DATA_W-1:0]   r_wdata, w_wdata_d;
  logic [BeW-1:0]      r_be_n, w_be_n_d;
  logic                r_ce_n, w_ce_n_d;
  logic                r_we_n, w_we_n_d;
  logic                r_oe, w_oe_d;
  logic [DATA_W-1:0]   r_rdata, w_rdata_d;
  logic                r_ack, w_ack_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be_n  <= '1;
      r_ce_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_oe    <= 1'b0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_dir   <= w_dir_d;
      r_addr  <= w_addr_d;
      r_wdata <= w_wdata_d;
      r_be_n  <= w_be_n_d;
      r_ce_n  <= w_ce_n_d;
      r_we_n  <= w_we_n_d;
      r_oe    <= w_oe_d;
      r_rdata <= w_rdata_d;
      r_ack   <= w_ack_d;
    end
  end

  // Next-state logic produces the pin values for the state being entered.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_dir_d   = r_dir;
    w_addr_d  = r_addr;
    w_wdata_d = r_wdata;
    w_be_n_d  = r_be_n;
    w_ce_n_d  = r_ce_n;
    w_we_n_d  = r_we_n;
    w_oe_d    = r_oe;
    w_rdata_d = r_rdata;
    w_ack_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (req_i) begin
          w_dir_d   = we_i;
          w_addr_d  = addr_i;
          w_wdata_d = wdata_i;
          w_be_n_d  = ~be_i;
          w_ce_n_d  = 1'b0;
          w_cnt_d   = WaitInit;
          if (we_i) begin
            w_state_d = StSetup;
            w_oe_d    = 1'b1;
          end else begin
            w_state_d = StAccess;
          end
        end
      end
      StSetup: begin
        w_state_d = StAccess;
        w_we_n_d  = 1'b0;
      end
      StAccess: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - 3'd1;
        end else if (r_dir) begin
          w_state_d = StHold;
          w_we_n_d  = 1'b1;
        end else begin
          w_state_d = StDone;
          w_ce_n_d  = 1'b1;
          w_be_n_d  = '1;
          w_ack_d   = 1'b1;
          w_rdata_d = base_ram_data;
        end
      end
      StHold: begin
        w_state_d = StDone;
        w_ce_n_d  = 1'b1;
        w_be_n_d  = '1;
        w_oe_d    = 1'b0;
        w_ack_d   = 1'b1;
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign base_ram_data = r_oe ? r_wdata : 'z;
  assign base_ram_addr = r_addr;
  assign base_ram_be_n = r_be_n;
  assign base_ram_ce_n = r_ce_n;
  assign base_ram_we_n = r_we_n;
  assign rdata_o       = r_rdata;
  assign ack_o         = r_ack;
  assign busy_o        = (r_state != StIdle);

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench: instance 0 built with WAIT_CYCLES=1, instance 1 with WAIT_CYCLES=0,
// each hooked to its own behavioural SRAM model.
module tb_sram_ctrl;

  localparam logic [31:0] PROBE = 32'hA5A5A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, req, we, ack, busy, ce_n, we_n, probe, cur_we;
  logic [1:0][19:0] addr, raddr;
  logic [1:0][31:0] wdata, rdata;
  logic [1:0][3:0]  be, be_n;
  wire  [31:0]      bus0, bus1;
  logic [31:0]      mem [2][1024];
  int               n_tests = 0;
  int               n_fail  = 0;

  sram_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst[0]), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .be_i(be[0]), .rdata_o(rdata[0]), .ack_o(ack[0]), .busy_o(busy[0]),
    .base_ram_data(bus0), .base_ram_addr(raddr[0]), .base_ram_be_n(be_n[0]),
    .base_ram_ce_n(ce_n[0]), .base_ram_we_n(we_n[0])
  );

  sram_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst[1]), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .be_i(be[1]), .rdata_o(rdata[1]), .ack_o(ack[1]), .busy_o(busy[1]),
    .base_ram_data(bus1), .base_ram_addr(raddr[1]), .base_ram_be_n(be_n[1]),
    .base_ram_ce_n(ce_n[1]), .base_ram_we_n(we_n[1])
  );

  // SRAM drives only for reads (no OE pin); probe drives a known pattern to detect release.
  assign bus0 = probe[0] ? PROBE :
                ((!ce_n[0] && we_n[0] && !cur_we[0]) ? mem[0][raddr[0][9:0]] : 'z);
  assign bus1 = probe[1] ? PROBE :
                ((!ce_n[1] && we_n[1] && !cur_we[1]) ? mem[1][raddr[1][9:0]] : 'z);

  always @(posedge clk) begin
    logic [31:0] v;
    for (int d = 0; d < 2; d++) begin
      v = (d == 0) ? bus0 : bus1;
      if (rst[d]) begin
        mem[d][10'h010] <= 32'hDEADBEEF;
        mem[d][10'h3CD] <= 32'hFFEEDDCC;
      end else if (!ce_n[d] && !we_n[d]) begin
        for (int b = 0; b < 4; b++)
          if (!be_n[d][b]) mem[d][raddr[d][9:0]][8*b +: 8] <= v[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bus_of(input int d);
    return (d == 0) ? bus0 : bus1;
  endfunction

  // One transaction with req pulsed for the accepting edge; monitors 20 cycles after T0.
  task automatic run_txn(input int d, input logic w, input logic [19:0] a,
                         input logic [31:0] wd, input logic [3:0] b,
                         output int ack_k, output int ce_cnt, output int we_cnt,
                         output logic pins_ok, output logic rel_ok, output logic busy_ok);
    int          we_first, we_last;
    logic [31:0] bus_h  [21];
    logic [19:0] addr_h [21];
    ack_k = -1; ce_cnt = 0; we_cnt = 0; we_first = -1; we_last = -1;
    pins_ok = 1'b1; rel_ok = 1'b1; busy_ok = 1'b1;
    @(negedge clk);
    we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b; cur_we[d] = w; req[d] = 1'b1;
    @(posedge clk);
    #1;
    req[d] = 1'b0; we[d] = ~w; addr[d] = ~a; wdata[d] = ~wd; be[d] = ~b;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus_h[k]  = bus_of(d);
      addr_h[k] = raddr[d];
      if (!ce_n[d]) begin
        ce_cnt++;
        if (raddr[d] !== a || be_n[d] !== ~b) pins_ok = 1'b0;
      end
      if (!we_n[d]) begin
        we_cnt++;
        if (we_first < 0) we_first = k;
        we_last = k;
      end
      if (ack[d]) ack_k = (ack_k < 0) ? k : 99;
      if (k == 1 && busy[d] !== 1'b1) busy_ok = 1'b0;
      if (ack_k == k && busy[d] !== 1'b1) busy_ok = 1'b0;
      if (ack_k > 0 && k == ack_k + 1 && busy[d] !== 1'b0) busy_ok = 1'b0;
      if (w && ack_k == k) begin
        probe[d] = 1'b1;
        #1;
        if (bus_of(d) !== PROBE) rel_ok = 1'b0;
        probe[d] = 1'b0;
      end
    end
    if (w) begin
      if (we_first < 2 || we_last > 19) pins_ok = 1'b0;
      else
        for (int k = we_first - 1; k <= we_last + 1; k++)
          if (bus_h[k] !== wd || addr_h[k] !== a) pins_ok = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   ak, cc, wc, j, nacks;
    logic pok, rok, bok;
    rst = 2'b11; req = 2'b11; we = 2'b00; probe = 2'b00; cur_we = 2'b00;
    addr[0] = 20'h00010; addr[1] = 20'h00010;
    wdata[0] = '0; wdata[1] = '0; be[0] = 4'hF; be[1] = 4'hF;

    // Reset held 3 cycles with req high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      probe = 2'b11;
      #1;
      for (int d = 0; d < 2; d++) begin
        check("rst_ce_n",  64'(ce_n[d]), 64'd1);
        check("rst_we_n",  64'(we_n[d]), 64'd1);
        check("rst_be_n",  64'(be_n[d]), 64'hF);
        check("rst_ack",   64'(ack[d]),  64'd0);
        check("rst_busy",  64'(busy[d]), 64'd0);
        check("rst_bus_z", 64'(bus_of(d)), 64'(PROBE));
      end
      probe = 2'b00;
    end
    check("rst_rdata", 64'(rdata[0]), 64'd0);
    check("rst_addr",  64'(raddr[0]), 64'd0);
    rst = 2'b00;
    @(negedge clk);
    req = 2'b00;
    check("rst_accept_busy", 64'(busy[0]), 64'd1);
    check("rst_accept_ce",   64'(ce_n[0]), 64'd0);
    repeat (8) @(negedge clk);
    check("rst_read_rdata_w1", 64'(rdata[0]), 64'hDEADBEEF);
    check("rst_read_rdata_w0", 64'(rdata[1]), 64'hDEADBEEF);

    // WAIT_CYCLES=1 read
    run_txn(0, 1'b0, 20'h00010, 32'h0, 4'hF, ak, cc, wc, pok, rok, bok);
    check("w1_rd_ack",   64'(ak), 64'd3);
    check("w1_rd_ce",    64'(cc), 64'd2);
    check("w1_rd_we",    64'(wc), 64'd0);
    check("w1_rd_pins",  64'(pok), 64'd1);
    check("w1_rd_busy",  64'(bok), 64'd1);
    check("w1_rd_rdata", 64'(rdata[0]), 64'hDEADBEEF);

    // WAIT_CYCLES=1 partial write
    run_txn(0, 1'b1, 20'h0ABCD, 32'h12345678, 4'b0011, ak, cc, wc, pok, rok, bok);
    check("w1_wr_ack",    64'(ak), 64'd5);
    check("w1_wr_ce",     64'(cc), 64'd4);
    check("w1_wr_we",     64'(wc), 64'd2);
    check("w1_wr_stable", 64'(pok), 64'd1);
    check("w1_wr_rel",    64'(rok), 64'd1);
    check("w1_wr_busy",   64'(bok), 64'd1);
    check("w1_wr_rdata_kept", 64'(rdata[0]), 64'hDEADBEEF);
    run_txn(0, 1'b0, 20'h0ABCD, 32'h0, 4'hF, ak, cc, wc, pok, rok, bok);
    check("w1_rb_ack",   64'(ak), 64'd3);
    check("w1_rb_rdata", 64'(rdata[0]), 64'hFFEE5678);

    // WAIT_CYCLES=0 build
    run_txn(1, 1'b0, 20'h00010, 32'h0, 4'hF, ak, cc, wc, pok, rok, bok);
    check("w0_rd_ack",   64'(ak), 64'd2);
    check("w0_rd_ce",    64'(cc), 64'd1);
    check("w0_rd_rdata", 64'(rdata[1]), 64'hDEADBEEF);
    run_txn(1, 1'b1, 20'h0ABCD, 32'h89ABCDEF, 4'b1000, ak, cc, wc, pok, rok, bok);
    check("w0_wr_ack",    64'(ak), 64'd4);
    check("w0_wr_ce",     64'(cc), 64'd3);
    check("w0_wr_we",     64'(wc), 64'd1);
    check("w0_wr_stable", 64'(pok), 64'd1);
    check("w0_wr_rel",    64'(rok), 64'd1);
    run_txn(1, 1'b0, 20'h0ABCD, 32'h0, 4'hF, ak, cc, wc, pok, rok, bok);
    check("w0_rb_rdata", 64'(rdata[1]), 64'h89EEDDCC);
    // be=0 write still runs the full cycle but changes nothing
    run_txn(1, 1'b1, 20'h00010, 32'h0, 4'h0, ak, cc, wc, pok, rok, bok);
    check("w0_be0_ack",  64'(ak), 64'd4);
    check("w0_be0_we",   64'(wc), 64'd1);
    check("w0_be0_pins", 64'(pok), 64'd1);
    run_txn(1, 1'b0, 20'h00010, 32'h0, 4'hF, ak, cc, wc, pok, rok, bok);
    check("w0_be0_rb", 64'(rdata[1]), 64'hDEADBEEF);

    // Back-to-back write then read with req held high
    @(negedge clk);
    we[0] = 1'b1; addr[0] = 20'h00020; wdata[0] = 32'hCAFEF00D; be[0] = 4'hF;
    cur_we[0] = 1'b1; req[0] = 1'b1;
    j = -1;
    for (int k = 1; k <= 20 && j < 0; k++) begin
      @(negedge clk);
      if (k == 2) addr[0] = 20'h55555;
      if (k == 3) check("b2b_addr_hold", 64'(raddr[0]), 64'h00020);
      if (ack[0]) j = k;
    end
    // first negedge after req is the accepting cycle+1, so write ack lands at k=5
    check("b2b_wr_ack", 64'(j), 64'd5);
    cur_we[0] = 1'b0; we[0] = 1'b0; addr[0] = 20'h00020;
    @(negedge clk);
    check("b2b_idle_gap", 64'(busy[0]), 64'd0);
    @(negedge clk);
    check("b2b_rd_start_busy", 64'(busy[0]), 64'd1);
    check("b2b_rd_start_ce",   64'(ce_n[0]), 64'd0);
    j = -1;
    for (int k = 1; k <= 10 && j < 0; k++) begin
      @(negedge clk);
      if (ack[0]) j = k;
    end
    req[0] = 1'b0;
    check("b2b_rd_ack", 64'(j), 64'd2);
    @(negedge clk);
    check("b2b_rd_rdata", 64'(rdata[0]), 64'hCAFEF00D);
    repeat (2) @(negedge clk);
    check("b2b_end_idle", 64'(busy[0]), 64'd0);

    // Abort: reset during write ACCESS
    @(negedge clk);
    we[0] = 1'b1; addr[0] = 20'h00030; wdata[0] = 32'h0F0F0F0F; be[0] = 4'hF;
    cur_we[0] = 1'b1; req[0] = 1'b1;
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_pre_we", 64'(we_n[0]), 64'd0);
    rst[0] = 1'b1;
    @(negedge clk);
    probe[0] = 1'b1;
    #1;
    check("abort_we_n", 64'(we_n[0]), 64'd1);
    check("abort_ce_n", 64'(ce_n[0]), 64'd1);
    check("abort_busy", 64'(busy[0]), 64'd0);
    check("abort_bus_z", 64'(bus0), 64'(PROBE));
    probe[0] = 1'b0;
    nacks = 0;
    if (ack[0]) nacks++;
    rst[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack[0]) nacks++;
    end
    check("abort_no_ack", 64'(nacks), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
